mmu_ppn_idb_bridge: RTL and testbench
=====================================

# mmu_ppn_idb_bridge

Clocked, parametrised byte-lane bridge between the MMU physical-page-number (PPN) field and the internal data bus (IDB), successor to the sheet-28 PPN/IDB transceiver pair. Reads sample the PPN into a per-lane holding register that drives the IDB. Writes merge IDB lanes into the current PPN and queue the composed word in a small FIFO with a valid/ready handshake toward the page-table RAM. A reduced-width mode on the top lane replaces the fixed "EIPUR" behaviour.

## Interface
- LANES, 2, number of byte lanes; data width W = LANES*LANE_W
- LANE_W, 8, bits per lane
- REDUCED_W, 1, low bits of the top lane kept in reduced mode (1..LANE_W)
- DEPTH, 4, write FIFO entries (power of two, >= 2)

- sysclk  in  1  system clock; all state updates on its rising edge
- sys_rst_n  in  1  reset; synchronous and active-low
- ESTOF_n  in  1  direction: 1 = PPN->IDB (read), 0 = IDB->PPN (write)
- EIP_n  in  LANES  per-lane enable, active-low
- EIPR_n  in  1  reduced mode for lane LANES-1, active-low
- IDB_IN  in  W  IDB value from the bus
- PPN_IN  in  W  current PPN value
- IDB_OUT  out  W  IDB value driven back onto the bus
- IDB_DRV  out  LANES  lanes currently driven by this block
- WR_VALID  out  1  FIFO head is valid
- WR_READY  in  1  consumer accepts the head
- PPN_OUT  out  W  FIFO head word; 0 when WR_VALID=0
- WR_MASK  out  LANES  lanes written in the head word
- WR_FULL  out  1  FIFO holds DEPTH entries
- OVERRUN  out  1  sticky flag: a write was dropped
- CLR_OVR  in  1  clears OVERRUN

## Operation
- Reduce function R(x): if EIPR_n=0, bits of lane LANES-1 above REDUCED_W are forced to 0 and the low REDUCED_W bits pass through. Other lanes are never affected.
- Read (ESTOF_n=1): each edge, for every lane with EIP_n[i]=0, rd_reg lane i <= R(PPN_IN) lane i and IDB_DRV[i] <= 1. Other lanes get IDB_DRV[i] <= 0.
- IDB_OUT lane i = rd_reg lane i when IDB_DRV[i]=1, otherwise IDB_IN lane i (combinational pass-through).
- Write (ESTOF_n=0): wr_act = any EIP_n low. A push occurs only on the first cycle of wr_act, i.e. when wr_act=1 and the registered wr_act from the previous cycle is 0. One push per strobe, however long the strobe lasts.
- Pushed word: lanes with EIP_n=0 take IDB_IN; other lanes take PPN_IN. R() is then applied to the whole word. Pushed mask = ~EIP_n.
- A direction change while lanes are enabled is treated as a new strobe, so wr_act restarts.
- FIFO: pop when WR_VALID & WR_READY. Push and pop in the same cycle are both performed and occupancy is unchanged.
- Push when full with no pop: the word is dropped and OVERRUN <= 1. Push when full with a simultaneous pop is accepted.
- OVERRUN is cleared by CLR_OVR=1. If a drop and CLR_OVR occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. Occupancy is a counter of log2(DEPTH)+1 bits.

## Timing
- Reset (sys_rst_n=0 at an edge): rd_reg=0, IDB_DRV=0, FIFO empty, WR_VALID=0, PPN_OUT=0, WR_MASK=0, WR_FULL=0, OVERRUN=0, registered wr_act=0.
- Reset asserted mid-strobe discards all queued words. A strobe still active when reset releases does not push until its enable deasserts and reasserts.
- Read latency: 1 cycle from the enable edge to IDB_OUT and IDB_DRV.
- Write latency: push edge to WR_VALID=1 is 1 cycle (registered; no bypass).
- PPN_OUT, WR_MASK, WR_VALID and WR_FULL are registered/derived from state only. WR_READY has no combinational path to any output.
- Throughput: one pop per cycle. One push per strobe, with a minimum of 2 cycles between pushes (strobe high, then idle).

## Test plan
- Read, LANES=2, LANE_W=8, REDUCED_W=1, EIPR_n=1: PPN_IN=16'hA5C3, EIP_n=2'b00, ESTOF_n=1 -> next cycle IDB_OUT=16'hA5C3, IDB_DRV=2'b11. EIP_n=2'b10 with IDB_IN=16'h1234 -> IDB_OUT=16'h12C3.
- Reduced write: ESTOF_n=0, EIPR_n=0, EIP_n=2'b00, IDB_IN=16'hFF7E, strobe held for 5 cycles, WR_READY=0 -> exactly one entry queued, PPN_OUT=16'h017E, WR_MASK=2'b11.
- Lane merge: PPN_IN=16'hABCD, EIP_n=2'b10, IDB_IN=16'h1122 -> PPN_OUT=16'hAB22, WR_MASK=2'b01.
- Full/overrun, DEPTH=4, WR_READY=0: 5 separate strobes -> WR_FULL=1 after the 4th, 5th dropped, OVERRUN=1. Then WR_READY=1 -> the 4 original words pop in order. CLR_OVR -> OVERRUN=0.
- Full with simultaneous push and pop: FIFO full, push on the same edge as a pop -> no overrun, occupancy stays 4, new word last out.
- Reset mid-operation: 3 entries queued, sys_rst_n=0 for 1 cycle while a strobe is active -> all outputs at reset values. No push until the strobe deasserts and reasserts.

Source files
------------

// File: rtl/mmu_ppn_idb_bridge_if.sv
// mmu_ppn_idb_bridge_if
//   Bus bundle between the PPN/IDB bridge and its environment.
//   The bridge uses the "slave" modport. The environment (MMU datapath,
//   IDB, page-table RAM consumer) uses the "master" modport.
//
//   Signals (W = LANES*LANE_W):
//     ESTOF_n   direction, 1 = PPN->IDB (read), 0 = IDB->PPN (write)
//     EIP_n     per-lane enable, active-low
//     EIPR_n    reduced mode for the top lane, active-low
//     IDB_IN    IDB value from the bus
//     PPN_IN    current PPN value
//     IDB_OUT   IDB value driven back onto the bus
//     IDB_DRV   lanes currently driven by the bridge
//     WR_VALID  write FIFO head is valid
//     WR_READY  consumer accepts the head
//     PPN_OUT   FIFO head word (0 when WR_VALID=0)
//     WR_MASK   lanes written in the head word
//     WR_FULL   FIFO holds DEPTH entries
//     OVERRUN   sticky, a write was dropped
//     CLR_OVR   clears OVERRUN
//
//   Handshake: a head word transfers on a rising edge where WR_VALID=1
//   and WR_READY=1. WR_VALID/PPN_OUT/WR_MASK stay stable until that
//   transfer. WR_READY may change freely and never combinationally
//   affects any bridge output.
interface mmu_ppn_idb_bridge_if #(
    parameter int LANES  = 2,
    parameter int LANE_W = 8
);
    localparam int W = LANES * LANE_W;

    logic             ESTOF_n;
    logic [LANES-1:0] EIP_n;
    logic             EIPR_n;
    logic [W-1:0]     IDB_IN;
    logic [W-1:0]     PPN_IN;
    logic [W-1:0]     IDB_OUT;
    logic [LANES-1:0] IDB_DRV;
    logic             WR_VALID;
    logic             WR_READY;
    logic [W-1:0]     PPN_OUT;
    logic [LANES-1:0] WR_MASK;
    logic             WR_FULL;
    logic             OVERRUN;
    logic             CLR_OVR;

    modport slave (
        input  ESTOF_n, EIP_n, EIPR_n, IDB_IN, PPN_IN, WR_READY, CLR_OVR,
        output IDB_OUT, IDB_DRV, WR_VALID, PPN_OUT, WR_MASK, WR_FULL, OVERRUN
    );

    modport master (
        output ESTOF_n, EIP_n, EIPR_n, IDB_IN, PPN_IN, WR_READY, CLR_OVR,
        input  IDB_OUT, IDB_DRV, WR_VALID, PPN_OUT, WR_MASK, WR_FULL, OVERRUN
    );
endinterface

// File: rtl/mmu_ppn_idb_bridge.sv
// mmu_ppn_idb_bridge
//   Clocked byte-lane bridge between the MMU PPN field and the IDB.
//   Read direction: enabled lanes of the (optionally reduced) PPN are
//   captured into a holding register that drives those IDB lanes one
//   cycle later; undriven lanes pass IDB_IN straight through.
//   Write direction: on the first cycle of each enable strobe, the IDB
//   lanes are merged into the PPN, reduced, and pushed with their lane
//   mask into a DEPTH-entry FIFO drained by a valid/ready consumer.
//
//   Ports:
//     sysclk     system clock, rising edge
//     sys_rst_n  synchronous active-low reset
//     bus_if     mmu_ppn_idb_bridge_if.slave (see interface header)
module mmu_ppn_idb_bridge #(
    parameter int LANES     = 2,
    parameter int LANE_W    = 8,
    parameter int REDUCED_W = 1,
    parameter int DEPTH     = 4
) (
    input  logic                    sysclk,
    input  logic                    sys_rst_n,
    mmu_ppn_idb_bridge_if.slave     bus_if
);
    localparam int W      = LANES * LANE_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int RED_LO = (LANES - 1) * LANE_W + REDUCED_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Reduced mode clears the top-lane bits above REDUCED_W; all lower
    // lanes are untouched.
    function automatic logic [W-1:0] reduce_word(input logic [W-1:0] x,
                                                 input logic       red_n);
        logic [W-1:0] r;
        r = x;
        if (!red_n) begin
            for (int b = RED_LO; b < W; b++) begin
                r[b] = 1'b0;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [W-1:0]     rd_q, rd_d;
    logic [LANES-1:0] drv_q, drv_d;
    logic [W-1:0]     ppn_red;
    logic [W-1:0]     idb_out;

    assign ppn_red = reduce_word(bus_if.PPN_IN, bus_if.EIPR_n);

    always_comb begin
        rd_d  = rd_q;
        drv_d = '0;
        for (int i = 0; i < LANES; i++) begin
            drv_d[i] = bus_if.ESTOF_n & ~bus_if.EIP_n[i];
            if (drv_d[i]) begin
                rd_d[i*LANE_W +: LANE_W] = ppn_red[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            rd_q  <= '0;
            drv_q <= '0;
        end else begin
            rd_q  <= rd_d;
            drv_q <= drv_d;
        end
    end

    // Driven lanes show the holding register, others echo the bus.
    always_comb begin
        idb_out = bus_if.IDB_IN;
        for (int i = 0; i < LANES; i++) begin
            if (drv_q[i]) begin
                idb_out[i*LANE_W +: LANE_W] = rd_q[i*LANE_W +: LANE_W];
            end
        end
    end

    assign bus_if.IDB_OUT = idb_out;
    assign bus_if.IDB_DRV = drv_q;

    // ------------------------------------------------------------------
    // Write strobe detection
    // ------------------------------------------------------------------
    // wr_act includes the direction, so a read->write flip with lanes
    // still enabled looks like a fresh rising edge of the strobe.
    // wr_hold_q is set by reset and held until wr_act drops, so a strobe
    // that straddles reset release never pushes.
    logic wr_act;
    logic wr_act_q;
    logic wr_hold_q;
    logic push_req;
    logic [W-1:0] merged;
    logic [W-1:0] wr_word;

    assign wr_act   = ~bus_if.ESTOF_n & ~(&bus_if.EIP_n);
    assign push_req = wr_act & ~wr_act_q & ~wr_hold_q;

    always_comb begin
        merged = bus_if.PPN_IN;
        for (int i = 0; i < LANES; i++) begin
            if (!bus_if.EIP_n[i]) begin
                merged[i*LANE_W +: LANE_W] = bus_if.IDB_IN[i*LANE_W +: LANE_W];
            end
        end
        wr_word = reduce_word(merged, bus_if.EIPR_n);
    end

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [W-1:0]     mem_word_q [DEPTH];
    logic [LANES-1:0] mem_mask_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             fifo_valid;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign fifo_valid = (cnt_q != '0);
    assign fifo_full  = (cnt_q == DEPTH_C);
    assign pop        = fifo_valid & bus_if.WR_READY;
    // A pop on the same edge frees the slot, so a full FIFO still
    // accepts the push.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q;
        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Set has priority over clear.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus_if.CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            wr_act_q  <= 1'b0;
            wr_hold_q <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            wr_act_q  <= wr_act;
            wr_hold_q <= wr_hold_q & wr_act;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge sysclk) begin
        if (sys_rst_n && push_ok) begin
            mem_word_q[wptr_q] <= wr_word;
            mem_mask_q[wptr_q] <= ~bus_if.EIP_n;
        end
    end

    assign bus_if.WR_VALID = fifo_valid;
    assign bus_if.PPN_OUT  = fifo_valid ? mem_word_q[rptr_q] : '0;
    assign bus_if.WR_MASK  = fifo_valid ? mem_mask_q[rptr_q] : '0;
    assign bus_if.WR_FULL  = fifo_full;
    assign bus_if.OVERRUN  = ovr_q;

endmodule

// File: tb/tb_mmu_ppn_idb_bridge.sv
module tb_mmu_ppn_idb_bridge;
  localparam int LANES = 2;
  localparam int LANE_W = 8;
  localparam int W = LANES * LANE_W;
  localparam int DEPTH = 4;

  logic sysclk;
  logic sys_rst_n;

  mmu_ppn_idb_bridge_if #(.LANES(LANES), .LANE_W(LANE_W)) bus();

  mmu_ppn_idb_bridge #(
    .LANES(LANES), .LANE_W(LANE_W), .REDUCED_W(1), .DEPTH(DEPTH)
  ) dut (
    .sysclk(sysclk),
    .sys_rst_n(sys_rst_n),
    .bus_if(bus.slave)
  );

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {mask, word}
  logic [LANES+W-1:0] exp_q[$];
  int model_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word(input logic [W-1:0] idb, input logic [W-1:0] ppn,
                                              input logic [LANES-1:0] eip, input logic eipr);
    logic [W-1:0] w;
    w[7:0]  = eip[0] ? ppn[7:0] : idb[7:0];
    w[15:8] = eip[1] ? ppn[15:8] : idb[15:8];
    if (!eipr) w[15:9] = 7'd0;
    return w;
  endfunction

  // one write strobe (one cycle active, one idle), WR_READY held low
  task automatic strobe(input logic [W-1:0] idb, input logic [W-1:0] ppn,
                        input logic [LANES-1:0] eip, input logic eipr);
    bus.ESTOF_n = 1'b0;
    bus.EIP_n = eip;
    bus.EIPR_n = eipr;
    bus.IDB_IN = idb;
    bus.PPN_IN = ppn;
    if (model_cnt < DEPTH) begin
      exp_q.push_back({~eip, model_word(idb, ppn, eip, eipr)});
      model_cnt++;
    end
    tick();
    bus.EIP_n = 2'b11;
    tick();
  endtask

  task automatic rand_strobe();
    logic [LANES-1:0] eip;
    eip = 2'($urandom_range(0, 2));
    strobe(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), eip, 1'b1);
  endtask

  // pop n head words, comparing each against the scoreboard
  task automatic drain(input int n);
    logic [LANES+W-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("drain_valid", 32'(bus.WR_VALID), 32'd1);
      chk("drain_word", 32'(bus.PPN_OUT), 32'(e[W-1:0]));
      chk("drain_mask", 32'(bus.WR_MASK), 32'(e[LANES+W-1:W]));
      bus.WR_READY = 1'b1;
      tick();
      if (model_cnt > 0) model_cnt--;
    end
    bus.WR_READY = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_drv"}, 32'(bus.IDB_DRV), 32'd0);
    chk({tag, "_valid"}, 32'(bus.WR_VALID), 32'd0);
    chk({tag, "_ppn_out"}, 32'(bus.PPN_OUT), 32'd0);
    chk({tag, "_mask"}, 32'(bus.WR_MASK), 32'd0);
    chk({tag, "_full"}, 32'(bus.WR_FULL), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.OVERRUN), 32'd0);
  endtask

  initial begin
    logic [LANES+W-1:0] e;
    sys_rst_n = 1'b0;
    bus.ESTOF_n = 1'b1;
    bus.EIP_n = 2'b11;
    bus.EIPR_n = 1'b1;
    bus.IDB_IN = 16'h5A5A;
    bus.PPN_IN = 16'h0000;
    bus.WR_READY = 1'b0;
    bus.CLR_OVR = 1'b0;

    // reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    chk("rst_passthru", 32'(bus.IDB_OUT), 32'h5A5A);
    sys_rst_n = 1'b1;
    tick();

    // read, full width
    bus.PPN_IN = 16'hA5C3;
    bus.EIP_n = 2'b00;
    tick();
    chk("rd_out", 32'(bus.IDB_OUT), 32'hA5C3);
    chk("rd_drv", 32'(bus.IDB_DRV), 32'h3);
    // read, low lane only
    bus.EIP_n = 2'b10;
    bus.IDB_IN = 16'h1234;
    tick();
    chk("rd_lane_out", 32'(bus.IDB_OUT), 32'h12C3);
    chk("rd_lane_drv", 32'(bus.IDB_DRV), 32'h1);
    // read, reduced
    bus.EIPR_n = 1'b0;
    bus.EIP_n = 2'b00;
    bus.PPN_IN = 16'hFFFF;
    tick();
    chk("rd_red_out", 32'(bus.IDB_OUT), 32'h01FF);
    // read released
    bus.EIP_n = 2'b11;
    tick();
    chk("rd_idle_drv", 32'(bus.IDB_DRV), 32'h0);
    chk("rd_idle_out", 32'(bus.IDB_OUT), 32'h1234);

    // reduced write held 5 cycles -> one entry
    bus.ESTOF_n = 1'b0;
    bus.EIP_n = 2'b00;
    bus.IDB_IN = 16'hFF7E;
    exp_q.push_back({2'b11, model_word(16'hFF7E, 16'hFFFF, 2'b00, 1'b0)});
    model_cnt++;
    for (int i = 0; i < 5; i++) tick();
    bus.EIP_n = 2'b11;
    tick();
    chk("red_word", 32'(bus.PPN_OUT), 32'h017E);
    drain(1);
    chk("held_one_entry", 32'(bus.WR_VALID), 32'd0);

    // lane merge
    strobe(16'h1122, 16'hABCD, 2'b10, 1'b1);
    chk("merge_word", 32'(bus.PPN_OUT), 32'hAB22);
    drain(1);

    // full / overrun
    for (int i = 0; i < DEPTH; i++) begin
      rand_strobe();
      chk("fill_full", 32'(bus.WR_FULL), 32'(i == DEPTH - 1));
    end
    chk("pre_ovr", 32'(bus.OVERRUN), 32'd0);
    rand_strobe();
    chk("ovr_set", 32'(bus.OVERRUN), 32'd1);
    chk("ovr_full", 32'(bus.WR_FULL), 32'd1);
    drain(DEPTH);
    chk("ovr_empty", 32'(bus.WR_VALID), 32'd0);
    chk("ovr_sticky", 32'(bus.OVERRUN), 32'd1);
    bus.CLR_OVR = 1'b1;
    tick();
    bus.CLR_OVR = 1'b0;
    chk("ovr_clr", 32'(bus.OVERRUN), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) rand_strobe();
    e = exp_q.pop_front();
    chk("pp_head_word", 32'(bus.PPN_OUT), 32'(e[W-1:0]));
    chk("pp_head_mask", 32'(bus.WR_MASK), 32'(e[LANES+W-1:W]));
    bus.ESTOF_n = 1'b0;
    bus.EIP_n = 2'b01;
    bus.IDB_IN = 16'hBEEF;
    bus.PPN_IN = 16'h4321;
    exp_q.push_back({2'b10, model_word(16'hBEEF, 16'h4321, 2'b01, 1'b1)});
    bus.WR_READY = 1'b1;
    tick();
    bus.WR_READY = 1'b0;
    bus.EIP_n = 2'b11;
    chk("pp_no_ovr", 32'(bus.OVERRUN), 32'd0);
    chk("pp_full", 32'(bus.WR_FULL), 32'd1);
    tick();
    drain(DEPTH);
    chk("pp_empty", 32'(bus.WR_VALID), 32'd0);

    // drop and clear on the same edge: set wins
    for (int i = 0; i < DEPTH; i++) rand_strobe();
    bus.CLR_OVR = 1'b1;
    bus.ESTOF_n = 1'b0;
    bus.EIP_n = 2'b00;
    tick();
    bus.CLR_OVR = 1'b0;
    bus.EIP_n = 2'b11;
    chk("set_wins", 32'(bus.OVERRUN), 32'd1);
    tick();
    drain(1);

    // reset mid-strobe with 3 entries queued
    chk("pre_rst_valid", 32'(bus.WR_VALID), 32'd1);
    bus.ESTOF_n = 1'b0;
    bus.EIP_n = 2'b00;
    bus.IDB_IN = 16'h0F0F;
    sys_rst_n = 1'b0;
    tick();
    chk_reset_outputs("mid_rst");
    exp_q.delete();
    model_cnt = 0;
    sys_rst_n = 1'b1;
    tick();
    tick();
    chk("rst_strobe_no_push", 32'(bus.WR_VALID), 32'd0);
    bus.EIP_n = 2'b11;
    tick();
    strobe(16'h0F0F, 16'h7788, 2'b00, 1'b1);
    chk("rst_repush", 32'(bus.WR_VALID), 32'd1);
    drain(1);
    chk("final_empty", 32'(bus.WR_VALID), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
